led_scan_scheduler: RTL and testbench

- Sequences frame and row scanning for the 2-RGB, 8-scan HUB75 driver fed from the AL422 FIFO.
- Per frame, pulses the AL422 read reset (al422_nrst). Then, for every row and bit plane, it issues a shift request to the pixel shifter, latches the shifted slice, and drives binary-weighted OE time.
- Shifting of the next slice overlaps display of the current slice.

---
 rtl/led_scan_scheduler.sv | 161 ++++++++++++++++
 tb/tb_led_scan_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_scheduler.sv
// Frame/row/bit-plane sequencer for a HUB75 panel fed from an AL422 FIFO.
// Shifting of the next slice overlaps the binary-weighted display of the current one.
module led_scan_scheduler #(
    parameter int unsigned ROWS    = 8,
    parameter int unsigned ROW_W   = 5,
    parameter int unsigned PLANES  = 4,
    parameter int unsigned PLANE_W = 2,
    parameter int unsigned BASE_OE = 16,
    parameter int unsigned LAT_W   = 2,
    parameter int unsigned RST_W   = 4
) (
    input  logic               in_clk,
    input  logic               in_rst,
    input  logic               shift_done,
    output logic               shift_start,
    output logic [ROW_W-1:0]   shift_row,
    output logic [PLANE_W-1:0] shift_plane,
    output logic               al422_nrst,
    output logic               frame_start,
    output logic               led_lat_out,
    output logic               led_oe_out,
    output logic [ROW_W-1:0]   led_row
);

    localparam int unsigned DISP_W = $clog2((BASE_OE << (PLANES - 1)) + 1);
    localparam int unsigned RCNT_W = $clog2(RST_W + 1);
    localparam int unsigned LCNT_W = $clog2(LAT_W + 1);

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_SHIFT = 2'd1,
        S_LATCH = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [RCNT_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [LCNT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [DISP_W-1:0]   disp_q, disp_d;
    logic                done_q, done_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [PLANE_W-1:0]  plane_q, plane_d;
    logic [ROW_W-1:0]    led_row_q, led_row_d;
    logic                shift_start_q, shift_start_d;
    logic                frame_start_q, frame_start_d;
    logic                nrst_q, nrst_d;
    logic                lat_q, lat_d;
    logic                oe_q, oe_d;
    logic                last_slice_c;
    logic                done_now_c;

    assign last_slice_c = (row_q == ROW_W'(ROWS - 1)) && (plane_q == PLANE_W'(PLANES - 1));
    assign done_now_c   = done_q | shift_done;

    // Counters hold the number of cycles already shown in the current state,
    // so every output is registered for the cycle the FSM is displaying.
    always_comb begin
        state_d       = state_q;
        rst_cnt_d     = rst_cnt_q;
        lat_cnt_d     = lat_cnt_q;
        done_d        = done_q;
        row_d         = row_q;
        plane_d       = plane_q;
        led_row_d     = led_row_q;
        shift_start_d = 1'b0;
        frame_start_d = 1'b0;
        nrst_d        = 1'b1;
        lat_d         = 1'b0;
        disp_d        = (disp_q != '0) ? disp_q - DISP_W'(1) : disp_q;

        case (state_q)
            S_RST: begin
                if (rst_cnt_q == RCNT_W'(RST_W)) begin
                    state_d       = S_SHIFT;
                    shift_start_d = 1'b1;
                end else begin
                    rst_cnt_d     = rst_cnt_q + RCNT_W'(1);
                    nrst_d        = 1'b0;
                    frame_start_d = (rst_cnt_q == '0);
                end
            end
            S_SHIFT: begin
                done_d = done_now_c;
                if (done_now_c && (disp_q == '0)) begin
                    state_d   = S_LATCH;
                    lat_cnt_d = LCNT_W'(1);
                    lat_d     = 1'b1;
                    led_row_d = row_q;
                end
            end
            S_LATCH: begin
                if (lat_cnt_q != LCNT_W'(LAT_W)) begin
                    lat_cnt_d = lat_cnt_q + LCNT_W'(1);
                    lat_d     = 1'b1;
                end else begin
                    disp_d = DISP_W'(BASE_OE) << plane_q;
                    done_d = 1'b0;
                    if (plane_q == PLANE_W'(PLANES - 1)) begin
                        plane_d = '0;
                        row_d   = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
                    end else begin
                        plane_d = plane_q + PLANE_W'(1);
                    end
                    if (last_slice_c) begin
                        state_d       = S_RST;
                        rst_cnt_d     = RCNT_W'(1);
                        nrst_d        = 1'b0;
                        frame_start_d = 1'b1;
                    end else begin
                        state_d       = S_SHIFT;
                        shift_start_d = 1'b1;
                    end
                end
            end
            default: state_d = S_RST;
        endcase

        oe_d = (disp_d == '0);
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q       <= S_RST;
            rst_cnt_q     <= '0;
            lat_cnt_q     <= '0;
            disp_q        <= '0;
            done_q        <= 1'b0;
            row_q         <= '0;
            plane_q       <= '0;
            led_row_q     <= '0;
            shift_start_q <= 1'b0;
            frame_start_q <= 1'b0;
            nrst_q        <= 1'b0;
            lat_q         <= 1'b0;
            oe_q          <= 1'b1;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            lat_cnt_q     <= lat_cnt_d;
            disp_q        <= disp_d;
            done_q        <= done_d;
            row_q         <= row_d;
            plane_q       <= plane_d;
            led_row_q     <= led_row_d;
            shift_start_q <= shift_start_d;
            frame_start_q <= frame_start_d;
            nrst_q        <= nrst_d;
            lat_q         <= lat_d;
            oe_q          <= oe_d;
        end
    end

    assign shift_start = shift_start_q;
    assign shift_row   = row_q;
    assign shift_plane = plane_q;
    assign al422_nrst  = nrst_q;
    assign frame_start = frame_start_q;
    assign led_lat_out = lat_q;
    assign led_oe_out  = oe_q;
    assign led_row     = led_row_q;

endmodule

// File: tb/tb_led_scan_scheduler.sv
// Directed bench for led_scan_scheduler: a shifter responder with programmable latency
// plus per-cycle event recording, checked against hand-derived timing.
module tb_led_scan_scheduler;

    logic       in_clk;
    logic       in_rst;
    logic       shift_done;
    logic       shift_start;
    logic [4:0] shift_row;
    logic [1:0] shift_plane;
    logic       al422_nrst;
    logic       frame_start;
    logic       led_lat_out;
    logic       led_oe_out;
    logic [4:0] led_row;

    led_scan_scheduler dut (
        .in_clk      (in_clk),
        .in_rst      (in_rst),
        .shift_done  (shift_done),
        .shift_start (shift_start),
        .shift_row   (shift_row),
        .shift_plane (shift_plane),
        .al422_nrst  (al422_nrst),
        .frame_start (frame_start),
        .led_lat_out (led_lat_out),
        .led_oe_out  (led_oe_out),
        .led_row     (led_row)
    );

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int cd = 0;
    int resp_delay = 10;
    int ss_since_lat = 0;
    int extra_ss = 0;
    int ovl = 0;
    int fs_cnt = 0;
    int lo_run = 0;
    int nr_run = 0;
    int nrst_oe_lo = 0;
    logic prev_lat = 1'b0;
    int ss_cyc[$];
    int ss_row[$];
    int ss_pl[$];
    int ss_dly[$];
    int lat_cyc[$];
    int lat_row[$];
    int oe_run[$];
    int nrst_run[$];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: sample after the edge, answer shift requests, record events.
    task automatic step();
        @(posedge in_clk);
        #1;
        cyc++;
        shift_done = 1'b0;
        if (in_rst) begin
            cd = 0;
            ss_since_lat = 0;
            shift_done = 1'b1;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) shift_done = 1'b1;
        end
        if (shift_start) begin
            ss_cyc.push_back(cyc);
            ss_row.push_back(int'(shift_row));
            ss_pl.push_back(int'(shift_plane));
            ss_dly.push_back(resp_delay);
            cd = resp_delay;
            ss_since_lat++;
        end
        if (led_lat_out && !prev_lat) begin
            lat_cyc.push_back(cyc);
            lat_row.push_back(int'(led_row));
            if (ss_since_lat != 1) extra_ss++;
            ss_since_lat = 0;
        end
        if (!led_oe_out) lo_run++;
        else if (lo_run > 0) begin
            oe_run.push_back(lo_run);
            lo_run = 0;
        end
        if (!in_rst) begin
            if (!al422_nrst) begin
                nr_run++;
                if (!led_oe_out) nrst_oe_lo++;
            end else if (nr_run > 0) begin
                nrst_run.push_back(nr_run);
                nr_run = 0;
            end
        end
        if (led_lat_out && !led_oe_out) ovl++;
        if (frame_start) fs_cnt++;
        prev_lat = led_lat_out;
    endtask

    // Three reset cycles, release, then the four-cycle FIFO reset and first request.
    task automatic reset_seq();
        in_rst = 1'b1;
        step();
        check_eq("rst_oe", int'(led_oe_out), 1);
        check_eq("rst_row", int'(led_row), 0);
        check_eq("rst_nrst", int'(al422_nrst), 0);
        check_eq("rst_lat", int'(led_lat_out), 0);
        check_eq("rst_ss", int'(shift_start), 0);
        step();
        step();
        check_eq("rst_fs", int'(frame_start), 0);
        check_eq("rst_srow", int'(shift_row), 0);
        check_eq("rst_splane", int'(shift_plane), 0);
        in_rst = 1'b0;
        step();
        check_eq("fr1_fs", int'(frame_start), 1);
        check_eq("fr1_nrst", int'(al422_nrst), 0);
        step();
        check_eq("fr2_fs", int'(frame_start), 0);
        check_eq("fr2_nrst", int'(al422_nrst), 0);
        step();
        step();
        check_eq("fr4_nrst", int'(al422_nrst), 0);
        check_eq("fr4_ss", int'(shift_start), 0);
        check_eq("fr4_oe", int'(led_oe_out), 1);
        step();
        check_eq("fr5_ss", int'(shift_start), 1);
        check_eq("fr5_nrst", int'(al422_nrst), 1);
        check_eq("fr5_srow", int'(shift_row), 0);
        check_eq("fr5_splane", int'(shift_plane), 0);
        check_eq("fr5_oe", int'(led_oe_out), 1);
    endtask

    initial begin
        int n;
        int exp_d;
        int wprev;
        int sidx;
        int lidx;
        in_rst = 1'b1;
        shift_done = 1'b0;

        reset_seq();
        check_eq("first_ss_cyc", ss_cyc.size() > 0 ? ss_cyc[0] : -1, 8);

        // Full first frame with a 10-cycle shifter, up to the first request of frame 2.
        n = 0;
        while (ss_cyc.size() < 33 && n < 4000) begin step(); n++; end
        check_eq("frame_a_ss_count", ss_cyc.size(), 33);
        check_eq("wrap_frame_starts", fs_cnt, 2);
        check_eq("wrap_nrst_with_oe_low", nrst_oe_lo, 4);

        // Early shifter answers (3 cycles), including requests made during plane 3.
        resp_delay = 3;
        n = 0;
        while (ss_cyc.size() < 41 && n < 4000) begin step(); n++; end
        check_eq("early_ss_count", ss_cyc.size(), 41);

        // Slow shifter (200 cycles).
        resp_delay = 200;
        n = 0;
        while (lat_cyc.size() < 45 && n < 4000) begin step(); n++; end
        check_eq("slow_lat_count", lat_cyc.size(), 45);

        if (lat_cyc.size() >= 45 && ss_cyc.size() >= 45) begin
            check_eq("lat0_cyc", lat_cyc[0], 19);
            for (int k = 0; k < 45; k++) begin
                check_eq($sformatf("lat_row[%0d]", k), lat_row[k], (k / 4) % 8);
                check_eq($sformatf("ss_row[%0d]", k), ss_row[k], (k / 4) % 8);
                check_eq($sformatf("ss_plane[%0d]", k), ss_pl[k], k % 4);
                if (k == 0) exp_d = 11;
                else if (k == 32) exp_d = 125;
                else begin
                    wprev = 16 << ((k - 1) % 4);
                    exp_d = (ss_dly[k] >= wprev) ? ss_dly[k] + 1 : wprev + 1;
                end
                check_eq($sformatf("req_to_latch[%0d]", k), lat_cyc[k] - ss_cyc[k], exp_d);
                if (k > 0)
                    check_eq($sformatf("latch_to_req[%0d]", k), ss_cyc[k] - lat_cyc[k-1],
                             (k == 32) ? 6 : 2);
            end
        end
        check_eq("oe_run_count", oe_run.size(), 44);
        if (oe_run.size() >= 44) begin
            for (int j = 0; j < 44; j++)
                check_eq($sformatf("oe_low[%0d]", j), oe_run[j], 16 << (j % 4));
        end

        // Reset in the middle of row 3 display.
        n = 0;
        while (led_oe_out && n < 200) begin step(); n++; end
        check_eq("mid_oe_low_seen", int'(led_oe_out), 0);
        check_eq("mid_row_before", int'(led_row), 3);
        resp_delay = 10;
        reset_seq();
        sidx = ss_cyc.size() - 1;
        lidx = lat_cyc.size();
        n = 0;
        while (lat_cyc.size() == lidx && n < 500) begin step(); n++; end
        check_eq("restart_latched", lat_cyc.size(), lidx + 1);
        if (lat_cyc.size() > lidx) begin
            check_eq("restart_req_to_latch", lat_cyc[lidx] - ss_cyc[sidx], 11);
            check_eq("restart_lat_row", lat_row[lidx], 0);
        end

        check_eq("oe_lat_overlap", ovl, 0);
        check_eq("extra_shift_starts", extra_ss, 0);
        check_eq("frame_starts_total", fs_cnt, 3);
        check_eq("nrst_runs", nrst_run.size(), 3);
        for (int r = 0; r < nrst_run.size(); r++)
            check_eq($sformatf("nrst_len[%0d]", r), nrst_run[r], 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
